resp_gen_buffered: RTL and testbench

//  Parametrised next-generation command response generator for the Enigma FSM controller.

---
 rtl/resp_gen_buffered.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_resp_gen_buffered.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_gen_buffered.sv
// Command response generator for the Enigma controller: builds OK / ERR / query-dump bytes
// into a small FIFO that is drained towards the UART transmitter independently of generation.
//
// state | meaning
// IDLE  | waiting for start; kind/code latched on the accepting cycle
// EMIT  | walking the response segments, at most one FIFO push per cycle
// DRAIN | generation finished, waiting for FIFO empty and no tx_start in flight
module resp_gen_buffered #(
    parameter int NUM_ROT     = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter bit ERR_CODE_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             resp_kind,
    input  logic [3:0]             err_code,
    output logic                   busy,
    output logic                   done,
    input  logic                   tx_busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    input  logic [1:0]             ukw_sel,
    input  logic [3*NUM_ROT-1:0]   rot_sel,
    input  logic [5*NUM_ROT-1:0]   ring,
    input  logic [5*NUM_ROT-1:0]   grnd,
    input  logic [5*NUM_ROT-1:0]   pos,
    input  logic [129:0]           plug_map
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] ROT_CR = 4'(2*NUM_ROT+3);
    localparam logic [3:0] ROT_LF = 4'(2*NUM_ROT+4);

    localparam logic [3:0] SEG_OK   = 4'd0;
    localparam logic [3:0] SEG_ERR  = 4'd1;
    localparam logic [3:0] SEG_UKW  = 4'd2;
    localparam logic [3:0] SEG_ROT  = 4'd3;
    localparam logic [3:0] SEG_RNG  = 4'd4;
    localparam logic [3:0] SEG_GRD  = 4'd5;
    localparam logic [3:0] SEG_POS  = 4'd6;
    localparam logic [3:0] SEG_PLGH = 4'd7;
    localparam logic [3:0] SEG_PLGS = 4'd8;
    localparam logic [3:0] SEG_EOL  = 4'd9;

    typedef enum logic [1:0] {IDLE, EMIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [3:0] seg, seg_nxt, idx;
    logic [4:0] plg_i;
    logic [1:0] sub;
    logic       any_pair;
    logic [3:0] code_q;

    logic       gen_push, seg_end, adv, gen_last, push, pop;
    logic [7:0] gen_byte, hdr_byte, fchar, hex_char;
    logic [31:0] hdr;
    logic [1:0] slot;
    logic [4:0] fval, partner;
    logic       pair;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, drain_done;

    function automatic logic [7:0] letter(input logic [4:0] v);
        return (v > 5'd25) ? 8'h3F : 8'h41 + {3'b000, v};
    endfunction

    // Field lines: idx 0..3 header, then field/space alternating, then CR LF.
    assign slot     = 2'(idx[3:1] - 3'd2);
    assign partner  = plug_map[plg_i*5 +: 5];
    assign pair     = (partner > plg_i) && (partner <= 5'd25);
    assign hex_char = (code_q < 4'd10) ? 8'h30 + {4'h0, code_q} : 8'h37 + {4'h0, code_q};

    always_comb begin
        case (seg)
            SEG_RNG: fval = ring[slot*5 +: 5];
            SEG_GRD: fval = grnd[slot*5 +: 5];
            default: fval = pos[slot*5 +: 5];
        endcase
        fchar = (seg == SEG_ROT) ? 8'h31 + {5'b00000, rot_sel[slot*3 +: 3]} : letter(fval);
    end

    always_comb begin
        case (seg)
            SEG_UKW: hdr = 32'h554B573A;
            SEG_ROT: hdr = 32'h524F543A;
            SEG_RNG: hdr = 32'h524E473A;
            SEG_GRD: hdr = 32'h4752443A;
            SEG_POS: hdr = 32'h504F533A;
            default: hdr = 32'h504C473A;
        endcase
        case (idx[1:0])
            2'd0:    hdr_byte = hdr[31:24];
            2'd1:    hdr_byte = hdr[23:16];
            2'd2:    hdr_byte = hdr[15:8];
            default: hdr_byte = hdr[7:0];
        endcase
    end

    always_comb begin
        gen_push = 1'b0;
        gen_byte = 8'h00;
        seg_end  = 1'b0;
        case (seg)
            SEG_OK: begin
                gen_push = 1'b1;
                seg_end  = (idx == 4'd3);
                case (idx[1:0])
                    2'd0:    gen_byte = 8'h4F;
                    2'd1:    gen_byte = 8'h4B;
                    2'd2:    gen_byte = 8'h0D;
                    default: gen_byte = 8'h0A;
                endcase
            end
            SEG_ERR: begin
                gen_push = 1'b1;
                if (ERR_CODE_EN) begin
                    seg_end = (idx == 4'd6);
                    case (idx)
                        4'd0:    gen_byte = 8'h45;
                        4'd1:    gen_byte = 8'h52;
                        4'd2:    gen_byte = 8'h52;
                        4'd3:    gen_byte = 8'h20;
                        4'd4:    gen_byte = hex_char;
                        4'd5:    gen_byte = 8'h0D;
                        default: gen_byte = 8'h0A;
                    endcase
                end else begin
                    seg_end = (idx == 4'd4);
                    case (idx)
                        4'd0:    gen_byte = 8'h45;
                        4'd1:    gen_byte = 8'h52;
                        4'd2:    gen_byte = 8'h52;
                        4'd3:    gen_byte = 8'h0D;
                        default: gen_byte = 8'h0A;
                    endcase
                end
            end
            SEG_UKW: begin
                gen_push = 1'b1;
                seg_end  = (idx == 4'd6);
                if (idx < 4'd4)       gen_byte = hdr_byte;
                else if (idx == 4'd4) gen_byte = 8'h41 + {6'b000000, ukw_sel};
                else if (idx == 4'd5) gen_byte = 8'h0D;
                else                  gen_byte = 8'h0A;
            end
            SEG_ROT, SEG_RNG, SEG_GRD, SEG_POS: begin
                gen_push = 1'b1;
                seg_end  = (idx == ROT_LF);
                if (idx < 4'd4)         gen_byte = hdr_byte;
                else if (idx == ROT_CR) gen_byte = 8'h0D;
                else if (idx == ROT_LF) gen_byte = 8'h0A;
                else if (idx[0])        gen_byte = 8'h20;
                else                    gen_byte = fchar;
            end
            SEG_PLGH: begin
                gen_push = 1'b1;
                seg_end  = (idx == 4'd3);
                gen_byte = hdr_byte;
            end
            SEG_PLGS: begin
                // sub 0: separator or first letter, sub 1: first letter, sub 2: partner letter
                case (sub)
                    2'd0: begin
                        if (pair) begin
                            gen_push = 1'b1;
                            gen_byte = any_pair ? 8'h20 : letter(plg_i);
                        end else begin
                            seg_end = (plg_i == 5'd25);
                        end
                    end
                    2'd1: begin
                        gen_push = 1'b1;
                        gen_byte = letter(plg_i);
                    end
                    default: begin
                        gen_push = 1'b1;
                        gen_byte = letter(partner);
                        seg_end  = (plg_i == 5'd25);
                    end
                endcase
            end
            SEG_EOL: begin
                gen_push = 1'b1;
                seg_end  = (idx == 4'd1);
                gen_byte = idx[0] ? 8'h0A : 8'h0D;
            end
            default: seg_end = 1'b1;
        endcase
    end

    always_comb begin
        case (seg)
            SEG_UKW:  seg_nxt = SEG_ROT;
            SEG_ROT:  seg_nxt = SEG_RNG;
            SEG_RNG:  seg_nxt = SEG_GRD;
            SEG_GRD:  seg_nxt = SEG_POS;
            SEG_POS:  seg_nxt = SEG_PLGH;
            SEG_PLGH: seg_nxt = SEG_PLGS;
            SEG_PLGS: seg_nxt = SEG_EOL;
            default:  seg_nxt = SEG_OK;
        endcase
    end

    assign adv      = (state == EMIT) && (!gen_push || !full);
    assign push     = (state == EMIT) && gen_push && !full;
    assign gen_last = adv && seg_end && ((seg == SEG_OK) || (seg == SEG_ERR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg      <= SEG_OK;
            idx      <= 4'd0;
            plg_i    <= 5'd0;
            sub      <= 2'd0;
            any_pair <= 1'b0;
            code_q   <= 4'd0;
        end else if ((state == IDLE) && start) begin
            seg      <= (resp_kind == 2'd0) ? SEG_OK : (resp_kind == 2'd2) ? SEG_UKW : SEG_ERR;
            idx      <= 4'd0;
            plg_i    <= 5'd0;
            sub      <= 2'd0;
            any_pair <= 1'b0;
            code_q   <= err_code;
        end else if (adv) begin
            if (seg == SEG_PLGS) begin
                if ((sub == 2'd0) && pair) begin
                    sub <= any_pair ? 2'd1 : 2'd2;
                end else if (sub == 2'd1) begin
                    sub <= 2'd2;
                end else begin
                    sub <= 2'd0;
                    if (sub == 2'd2) any_pair <= 1'b1;
                    if (seg_end) begin
                        seg <= seg_nxt;
                        idx <= 4'd0;
                    end else begin
                        plg_i <= plg_i + 5'd1;
                    end
                end
            end else if (seg_end) begin
                seg <= seg_nxt;
                idx <= 4'd0;
            end else begin
                idx <= idx + 4'd1;
            end
        end
    end

    // Generator FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EMIT;
            EMIT:    if (gen_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EMIT) || ((state == DRAIN) && !drain_done);
        done = (state == DRAIN) && drain_done;
    end

    // TX FIFO; full is registered so a pop never frees a slot for a push in the same cycle.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !empty && !tx_busy && !tx_start;
    assign drain_done = empty && !tx_start;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= gen_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            tx_start <= pop;
            if (pop) begin
                tx_byte <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_resp_gen_buffered.sv
// Bench for resp_gen_buffered: a 3-rotor/ERR-code/8-deep instance and a 4-rotor/no-code/4-deep
// instance share stimulus; each byte stream is compared against strings built from the rules.
module tb_resp_gen_buffered;

    logic clk = 1'b0;
    logic rst, start, tx_busy;
    logic [1:0] resp_kind, ukw_sel;
    logic [3:0] err_code;
    logic [11:0] rot_v;
    logic [19:0] ring_v, grnd_v, pos_v;
    logic [129:0] plug_v;
    logic busy_a, done_a, tx_start_a, busy_b, done_b, tx_start_b;
    logic [7:0] tx_byte_a, tx_byte_b;

    always #5 clk = ~clk;

    resp_gen_buffered #(.NUM_ROT(3), .FIFO_DEPTH(8), .ERR_CODE_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .resp_kind(resp_kind), .err_code(err_code),
        .busy(busy_a), .done(done_a), .tx_busy(tx_busy), .tx_byte(tx_byte_a),
        .tx_start(tx_start_a), .ukw_sel(ukw_sel), .rot_sel(rot_v[8:0]), .ring(ring_v[14:0]),
        .grnd(grnd_v[14:0]), .pos(pos_v[14:0]), .plug_map(plug_v));

    resp_gen_buffered #(.NUM_ROT(4), .FIFO_DEPTH(4), .ERR_CODE_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .resp_kind(resp_kind), .err_code(err_code),
        .busy(busy_b), .done(done_b), .tx_busy(tx_busy), .tx_byte(tx_byte_b),
        .tx_start(tx_start_b), .ukw_sel(ukw_sel), .rot_sel(rot_v), .ring(ring_v),
        .grnd(grnd_v), .pos(pos_v), .plug_map(plug_v));

    int ukw;
    int rot[4], ring[4], grnd[4], pos[4], plug[26];
    int n_tests = 0, n_fail = 0;

    // Monitor: collect bytes, count done pulses, flag back-to-back or busy-violating tx_start.
    byte qa[$], qb[$];
    int cyc = 0, done_na, done_nb, last_ts_a, last_ts_b, done_cyc_a, done_cyc_b, viol_a, viol_b;
    logic pts_a = 1'b0, pts_b = 1'b0, txb_e = 1'b0;

    always @(posedge clk) txb_e <= tx_busy;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (tx_start_a) begin
                qa.push_back(tx_byte_a);
                if (pts_a || txb_e) viol_a++;
                last_ts_a = cyc;
            end
            if (tx_start_b) begin
                qb.push_back(tx_byte_b);
                if (pts_b || txb_e) viol_b++;
                last_ts_b = cyc;
            end
            if (done_a) begin done_na++; done_cyc_a = cyc; end
            if (done_b) begin done_nb++; done_cyc_b = cyc; end
        end
        pts_a = tx_start_a;
        pts_b = tx_start_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string printable(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      r = {r, "~"};
            else if (s[i] == 8'h0A) r = {r, "|"};
            else                    r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    task automatic chk_str(input string tag, input string obs, input string exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, printable(obs), printable(exp));
        end
    endtask

    function automatic string qstr(input byte q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%c", q[i])};
        return s;
    endfunction

    function automatic string fld(input int v);
        return (v > 25) ? "?" : $sformatf("%c", 65 + v);
    endfunction

    // Reference: the response text straight from the format rules.
    function automatic string model(input int kind, input int code, input int nrot, input bit err_en);
        string s, pl, hx;
        string nm[4];
        hx = "0123456789ABCDEF";
        if (kind == 0) return "OK\r\n";
        if (kind != 2) return err_en ? $sformatf("ERR %c\r\n", hx[code]) : "ERR\r\n";
        s = $sformatf("UKW:%c\r\n", 65 + ukw);
        nm[0] = "ROT"; nm[1] = "RNG"; nm[2] = "GRD"; nm[3] = "POS";
        for (int l = 0; l < 4; l++) begin
            s = {s, nm[l], ":"};
            for (int i = 0; i < nrot; i++) begin
                if (i > 0) s = {s, " "};
                case (l)
                    0:       s = {s, $sformatf("%0d", rot[i] + 1)};
                    1:       s = {s, fld(ring[i])};
                    2:       s = {s, fld(grnd[i])};
                    default: s = {s, fld(pos[i])};
                endcase
            end
            s = {s, "\r\n"};
        end
        pl = "";
        for (int i = 0; i < 26; i++) begin
            if (plug[i] > i && plug[i] <= 25) begin
                if (pl.len() > 0) pl = {pl, " "};
                pl = {pl, fld(i), fld(plug[i])};
            end
        end
        return {s, "PLG:", pl, "\r\n", "OK\r\n"};
    endfunction

    task automatic apply_cfg();
        ukw_sel = 2'(ukw);
        for (int s = 0; s < 4; s++) begin
            rot_v[3*s +: 3]  = 3'(rot[s]);
            ring_v[5*s +: 5] = 5'(ring[s]);
            grnd_v[5*s +: 5] = 5'(grnd[s]);
            pos_v[5*s +: 5]  = 5'(pos[s]);
        end
        for (int i = 0; i < 26; i++) plug_v[5*i +: 5] = 5'(plug[i]);
    endtask

    task automatic directed_cfg(input bit pairs);
        ukw = 1;
        for (int s = 0; s < 4; s++) begin rot[s] = s; ring[s] = 0; grnd[s] = 0; pos[s] = 0; end
        ring[3] = 27; pos[2] = 25; pos[3] = 5;
        for (int i = 0; i < 26; i++) plug[i] = i;
        if (pairs) begin plug[0] = 1; plug[1] = 0; plug[24] = 25; plug[25] = 24; end
        apply_cfg();
    endtask

    task automatic random_cfg();
        int a, b;
        ukw = $urandom_range(0, 3);
        for (int s = 0; s < 4; s++) begin
            rot[s] = $urandom_range(0, 7);
            ring[s] = $urandom_range(0, 28);
            grnd[s] = $urandom_range(0, 28);
            pos[s] = $urandom_range(0, 28);
        end
        for (int i = 0; i < 26; i++) plug[i] = i;
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 26; i++) plug[i] = $urandom_range(0, 31);
        end else begin
            for (int k = 0; k < 8; k++) begin
                a = $urandom_range(0, 25);
                b = $urandom_range(0, 25);
                if (a != b && plug[a] == a && plug[b] == b) begin plug[a] = b; plug[b] = a; end
            end
        end
        apply_cfg();
    endtask

    task automatic clear_mon();
        qa.delete(); qb.delete();
        done_na = 0; done_nb = 0; viol_a = 0; viol_b = 0;
        last_ts_a = 0; last_ts_b = 0; done_cyc_a = -1; done_cyc_b = -1;
    endtask

    // mode 0: tx_busy low, 1: random tx_busy, 2: tx_busy high for the first 200 cycles
    task automatic run_txn(input int kind, input int code, input int mode, input bit poke, input bit lat);
        string ea, eb;
        int t;
        ea = model(kind, code, 3, 1'b1);
        eb = model(kind, code, 4, 1'b0);
        clear_mon();
        resp_kind = 2'(kind);
        err_code = 4'(code);
        tx_busy = (mode == 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_a_after_start", busy_a, 1);
        chk("busy_b_after_start", busy_b, 1);
        if (lat) begin
            chk("ts_a_k1", tx_start_a, 0);
            @(negedge clk);
            chk("ts_a_k2", tx_start_a, 0);
            chk("ts_b_k2", tx_start_b, 0);
            @(negedge clk);
            chk("ts_a_k3", tx_start_a, 1);
            chk("byte_a_first", tx_byte_a, 32'(ea[0]));
            chk("ts_b_k3", tx_start_b, 1);
            chk("byte_b_first", tx_byte_b, 32'(eb[0]));
        end
        if (poke) begin
            resp_kind = 2'((kind + 1) % 4);
            err_code = ~4'(code);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            resp_kind = 2'(kind);
            err_code = 4'(code);
        end
        t = 0;
        while ((done_na == 0 || done_nb == 0) && t < 4000) begin
            @(negedge clk);
            t++;
            case (mode)
                0:       tx_busy = 1'b0;
                1:       tx_busy = 1'($urandom_range(0, 1));
                default: tx_busy = (t < 200);
            endcase
            if (mode == 2 && t == 199) begin
                chk("hold_busy_a", busy_a, 1);
                chk("hold_busy_b", busy_b, 1);
                chk("hold_bytes_a", qa.size(), 0);
                chk("hold_bytes_b", qb.size(), 0);
            end
        end
        chk("done_within_budget", (t < 4000), 1);
        tx_busy = 1'b0;
        repeat (12) @(negedge clk);
        chk_str("stream_a", qstr(qa), ea);
        chk_str("stream_b", qstr(qb), eb);
        chk("done_count_a", done_na, 1);
        chk("done_count_b", done_nb, 1);
        chk("done_after_last_ts_a", done_cyc_a, last_ts_a + 1);
        chk("done_after_last_ts_b", done_cyc_b, last_ts_b + 1);
        chk("ts_spacing_a", viol_a, 0);
        chk("ts_spacing_b", viol_b, 0);
        chk("busy_a_end", busy_a, 0);
        chk("busy_b_end", busy_b, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_busy = 1'b0; resp_kind = 2'd0; err_code = 4'd0;
        directed_cfg(1'b1);
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_ts_a", tx_start_a, 0);
        chk("rst_byte_a", tx_byte_a, 8'h00);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_ts_b", tx_start_b, 0);
        chk("rst_byte_b", tx_byte_b, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(0, 0, 0, 1'b0, 1'b1);
        run_txn(1, 10, 0, 1'b0, 1'b0);
        run_txn(2, 0, 0, 1'b1, 1'b0);
        chk_str("query_literal_a", qstr(qa),
                "UKW:B\r\nROT:1 2 3\r\nRNG:A A A\r\nGRD:A A A\r\nPOS:A A Z\r\nPLG:AB YZ\r\nOK\r\n");
        directed_cfg(1'b0);
        run_txn(2, 0, 0, 1'b0, 1'b0);
        directed_cfg(1'b1);
        run_txn(2, 0, 2, 1'b0, 1'b0);
        run_txn(3, 15, 1, 1'b1, 1'b0);

        // Reset in the middle of a query response
        clear_mon();
        resp_kind = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (112) @(negedge clk);
        chk("pre_rst_busy_a", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ts_a", tx_start_a, 0);
        chk("mid_rst_busy_a", busy_a, 0);
        chk("mid_rst_ts_b", tx_start_b, 0);
        chk("mid_rst_busy_b", busy_b, 0);
        clear_mon();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_bytes_a", qa.size(), 0);
        chk("post_rst_bytes_b", qb.size(), 0);
        chk("post_rst_busy_a", busy_a, 0);
        run_txn(0, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            random_cfg();
            run_txn($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1), r[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
